// File: rtl/alu_seq_if.sv
// Request channel of the ALU sequencer: a valid/ready handshake that carries
// one operation code and one operand per transfer.
interface alu_seq_if #(
  parameter int SIZE = 8
);
  logic            i_valid;
  logic            o_ready;
  logic [1:0]      i_op;
  logic [SIZE-1:0] i_operand;

  // The requester drives valid/op/operand and watches ready
  modport master (
    output i_valid,
    output i_op,
    output i_operand,
    input  o_ready
  );

  // The sequencer consumes the request and reports when it can take one
  modport slave (
    input  i_valid,
    input  i_op,
    input  i_operand,
    output o_ready
  );
endinterface

// File: rtl/alu_seq.sv
// Sequencing front end for the combinational ALU. It takes one request at a
// time, drives the ALU operands, folds the ALU sum back into an accumulator
// and reports completion plus zero/negative/overflow flags. MUL reuses the
// ALU adder as a shift-add multiplier over SIZE cycles.
module alu_seq #(
  parameter int SIZE = 8
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  alu_seq_if.slave        req,
  output logic [SIZE-1:0] o_alu_s1,
  output logic [SIZE-1:0] o_alu_s2,
  output logic            o_alu_en,
  output logic [2:0]      o_alu_func,
  input  logic [SIZE-1:0] i_alu_result,
  input  logic            i_alu_carry,
  output logic [SIZE-1:0] o_acc,
  output logic            o_done,
  output logic            o_zero,
  output logic            o_negative,
  output logic            o_overflow
);

  localparam int CW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SIZE - 1);

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_ADD  = 2'b10;
  localparam logic [1:0] OP_MUL  = 2'b11;

  typedef enum logic [1:0] {IDLE, EXEC, MUL, DONE} state_t;

  state_t          state_q, state_d;
  logic [SIZE-1:0] acc_q, acc_d;
  logic            ovf_q, ovf_d;
  logic            zero_q, zero_d;
  logic            neg_q, neg_d;
  logic [SIZE-1:0] operand_q, operand_d;
  logic [SIZE-1:0] p_q, p_d;
  logic [SIZE-1:0] m_q, m_d;
  logic [SIZE-1:0] q_q, q_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            sticky_q, sticky_d;
  logic [SIZE-1:0] alu_s1;
  logic [SIZE-1:0] alu_s2;
  logic            alu_en;

  // State register plus all datapath registers; reset lands in IDLE with an
  // empty accumulator, so the zero flag starts out set
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      ovf_q     <= 1'b0;
      zero_q    <= 1'b1;
      neg_q     <= 1'b0;
      operand_q <= '0;
      p_q       <= '0;
      m_q       <= '0;
      q_q       <= '0;
      cnt_q     <= '0;
      sticky_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      ovf_q     <= ovf_d;
      zero_q    <= zero_d;
      neg_q     <= neg_d;
      operand_q <= operand_d;
      p_q       <= p_d;
      m_q       <= m_d;
      q_q       <= q_d;
      cnt_q     <= cnt_d;
      sticky_q  <= sticky_d;
    end
  end

  // Next-state and ALU drive; the MUL overflow is sticky across the loop and
  // also catches multiplicand bits shifted off the top while multiplier bits
  // that would still have used them remain
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    ovf_d     = ovf_q;
    operand_d = operand_q;
    p_d       = p_q;
    m_d       = m_q;
    q_d       = q_q;
    cnt_d     = cnt_q;
    sticky_d  = sticky_q;
    alu_s1    = '0;
    alu_s2    = '0;
    alu_en    = 1'b0;

    case (state_q)
      IDLE: begin
        if (req.i_valid) begin
          operand_d = req.i_operand;
          case (req.i_op)
            OP_NOP: begin
              ovf_d   = 1'b0;
              state_d = DONE;
            end
            OP_LOAD: begin
              acc_d   = req.i_operand;
              ovf_d   = 1'b0;
              state_d = DONE;
            end
            OP_ADD: begin
              state_d = EXEC;
            end
            OP_MUL: begin
              p_d      = '0;
              m_d      = acc_q;
              q_d      = req.i_operand;
              cnt_d    = '0;
              sticky_d = 1'b0;
              state_d  = MUL;
            end
            default: state_d = IDLE;
          endcase
        end
      end
      EXEC: begin
        alu_s1  = acc_q;
        alu_s2  = operand_q;
        alu_en  = 1'b1;
        acc_d   = i_alu_result;
        ovf_d   = i_alu_carry;
        state_d = DONE;
      end
      MUL: begin
        alu_s1   = p_q;
        alu_s2   = q_q[0] ? m_q : '0;
        alu_en   = 1'b1;
        p_d      = i_alu_result;
        m_d      = m_q << 1;
        q_d      = q_q >> 1;
        sticky_d = sticky_q | i_alu_carry | (m_q[SIZE-1] && ((q_q >> 1) != '0));
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          acc_d   = i_alu_result;
          ovf_d   = sticky_d;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    zero_d = (acc_d == '0);
    neg_d  = acc_d[SIZE-1];
  end

  assign req.o_ready = (state_q == IDLE);
  assign o_done      = (state_q == DONE);
  assign o_alu_s1    = alu_s1;
  assign o_alu_s2    = alu_s2;
  assign o_alu_en    = alu_en;
  assign o_alu_func  = 3'b000;
  assign o_acc       = acc_q;
  assign o_zero      = zero_q;
  assign o_negative  = neg_q;
  assign o_overflow  = ovf_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: a behavioural adder stands in for the ALU, a directed
// table covers the named corner cases, then random operations are checked
// against an arithmetic model of the accumulator.
module tb_alu_seq;

  localparam int SIZE = 8;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_ADD  = 2'b10;
  localparam logic [1:0] OP_MUL  = 2'b11;

  logic            clk;
  logic            rst_n;
  logic [SIZE-1:0] alu_s1;
  logic [SIZE-1:0] alu_s2;
  logic            alu_en;
  logic [2:0]      alu_func;
  logic [SIZE-1:0] alu_result;
  logic            alu_carry;
  logic [SIZE-1:0] acc;
  logic            done;
  logic            zero;
  logic            negative;
  logic            overflow;

  int checks = 0;
  int errors = 0;

  logic [SIZE-1:0] ref_acc;
  logic            ref_ovf;

  alu_seq_if #(.SIZE(SIZE)) bus ();

  alu_seq #(.SIZE(SIZE)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .req          (bus),
    .o_alu_s1     (alu_s1),
    .o_alu_s2     (alu_s2),
    .o_alu_en     (alu_en),
    .o_alu_func   (alu_func),
    .i_alu_result (alu_result),
    .i_alu_carry  (alu_carry),
    .o_acc        (acc),
    .o_done       (done),
    .o_zero       (zero),
    .o_negative   (negative),
    .o_overflow   (overflow)
  );

  // Combinational unsigned adder playing the ALU
  assign {alu_carry, alu_result} = {1'b0, alu_s1} + {1'b0, alu_s2};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]      op;
    logic [SIZE-1:0] operand;
    logic [SIZE-1:0] exp_acc;
    logic            exp_ovf;
    int              exp_lat;
  } vec_t;

  vec_t vecs[$];

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Reference behaviour: plain arithmetic on the accumulator
  task automatic model_step(input logic [1:0] op, input logic [SIZE-1:0] opnd);
    int unsigned full;
    case (op)
      OP_NOP:  ref_ovf = 1'b0;
      OP_LOAD: begin ref_acc = opnd; ref_ovf = 1'b0; end
      OP_ADD: begin
        full    = int'(ref_acc) + int'(opnd);
        ref_acc = SIZE'(full);
        ref_ovf = (full > (2**SIZE - 1));
      end
      default: begin
        full    = int'(ref_acc) * int'(opnd);
        ref_acc = SIZE'(full);
        ref_ovf = (full > (2**SIZE - 1));
      end
    endcase
  endtask

  function automatic int expected_latency(input logic [1:0] op);
    if (op == OP_ADD) return 2;
    if (op == OP_MUL) return SIZE + 1;
    return 1;
  endfunction

  // One full request: handshake, in-flight checks, completion checks against
  // the model. Called and returning on a falling edge.
  task automatic apply_stimulus(input logic [1:0] op, input logic [SIZE-1:0] opnd,
                                output int lat);
    int guard = 0;
    logic busy_ok = 1'b1;
    logic [SIZE-1:0] prev_acc = ref_acc;
    while (!bus.o_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check_output("ready_before_req", bus.o_ready, 1'b1);
    bus.i_valid   = 1'b1;
    bus.i_op      = op;
    bus.i_operand = opnd;
    @(negedge clk);
    bus.i_valid = 1'b0;
    lat = 1;
    case (op)
      OP_ADD: begin
        check_output("exec_s1", alu_s1, prev_acc);
        check_output("exec_s2", alu_s2, opnd);
        check_output("exec_en", alu_en, 1'b1);
      end
      OP_MUL: begin
        check_output("mul_s1", alu_s1, '0);
        check_output("mul_s2", alu_s2, opnd[0] ? prev_acc : '0);
        check_output("mul_en", alu_en, 1'b1);
      end
      default: check_output("done_alu_en", alu_en, 1'b0);
    endcase
    while (!done && lat < 2 * SIZE + 4) begin
      if (bus.o_ready) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    model_step(op, opnd);
    check_output("done_seen", done, 1'b1);
    check_output("ready_low_busy", busy_ok && !bus.o_ready, 1'b1);
    check_output("latency", lat, expected_latency(op));
    check_output("acc", acc, ref_acc);
    check_output("overflow", overflow, ref_ovf);
    check_output("zero", zero, ref_acc == '0);
    check_output("negative", negative, ref_acc[SIZE-1]);
    check_output("func", alu_func, 3'b000);
    @(negedge clk);
    check_output("done_one_cycle", done, 1'b0);
    check_output("ready_after_done", bus.o_ready, 1'b1);
  endtask

  // Global time limit so the run always ends
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Main sequence: reset, directed table, corner sequences, random ops
  initial begin
    int lat;
    int ready_cnt;
    int done_cnt;
    logic done_bad;

    bus.i_valid   = 1'b0;
    bus.i_op      = OP_NOP;
    bus.i_operand = '0;
    rst_n         = 1'b0;
    ref_acc       = '0;
    ref_ovf       = 1'b0;

    vecs.push_back('{OP_LOAD, 8'h7F, 8'h7F, 1'b0, 1});
    vecs.push_back('{OP_ADD,  8'h01, 8'h80, 1'b0, 2});
    vecs.push_back('{OP_LOAD, 8'hFF, 8'hFF, 1'b0, 1});
    vecs.push_back('{OP_ADD,  8'h01, 8'h00, 1'b1, 2});
    vecs.push_back('{OP_NOP,  8'h00, 8'h00, 1'b0, 1});
    vecs.push_back('{OP_LOAD, 8'h0C, 8'h0C, 1'b0, 1});
    vecs.push_back('{OP_MUL,  8'h0B, 8'h84, 1'b0, 9});
    vecs.push_back('{OP_LOAD, 8'h10, 8'h10, 1'b0, 1});
    vecs.push_back('{OP_MUL,  8'h10, 8'h00, 1'b1, 9});
    vecs.push_back('{OP_LOAD, 8'hFF, 8'hFF, 1'b0, 1});
    vecs.push_back('{OP_MUL,  8'hFF, 8'h01, 1'b1, 9});
    vecs.push_back('{OP_NOP,  8'h55, 8'h01, 1'b0, 1});
    vecs.push_back('{OP_LOAD, 8'h00, 8'h00, 1'b0, 1});
    vecs.push_back('{OP_MUL,  8'h37, 8'h00, 1'b0, 9});
    vecs.push_back('{OP_LOAD, 8'h25, 8'h25, 1'b0, 1});
    vecs.push_back('{OP_MUL,  8'h00, 8'h00, 1'b0, 9});
    vecs.push_back('{OP_LOAD, 8'h81, 8'h81, 1'b0, 1});
    vecs.push_back('{OP_MUL,  8'h02, 8'h02, 1'b1, 9});
    vecs.push_back('{OP_LOAD, 8'h40, 8'h40, 1'b0, 1});
    vecs.push_back('{OP_MUL,  8'h03, 8'hC0, 1'b0, 9});

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    check_output("rst_acc", acc, 8'h00);
    check_output("rst_zero", zero, 1'b1);
    check_output("rst_negative", negative, 1'b0);
    check_output("rst_overflow", overflow, 1'b0);
    check_output("rst_ready", bus.o_ready, 1'b1);
    check_output("rst_alu_en", alu_en, 1'b0);
    check_output("rst_done", done, 1'b0);
    check_output("rst_s1", alu_s1, 8'h00);
    check_output("rst_s2", alu_s2, 8'h00);

    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].op, vecs[i].operand, lat);
      check_output($sformatf("vec%0d_lat", i), lat, vecs[i].exp_lat);
      check_output($sformatf("vec%0d_acc", i), acc, vecs[i].exp_acc);
      check_output($sformatf("vec%0d_ovf", i), overflow, vecs[i].exp_ovf);
    end

    // Reset in the middle of a multiply
    apply_stimulus(OP_LOAD, 8'h03, lat);
    bus.i_valid   = 1'b1;
    bus.i_op      = OP_MUL;
    bus.i_operand = 8'h05;
    @(negedge clk);
    bus.i_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    ref_acc = '0;
    ref_ovf = 1'b0;
    check_output("midmul_rst_acc", acc, 8'h00);
    check_output("midmul_rst_done", done, 1'b0);
    check_output("midmul_rst_zero", zero, 1'b1);
    check_output("midmul_rst_alu_en", alu_en, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    done_bad = 1'b0;
    @(negedge clk);
    check_output("midmul_ready", bus.o_ready, 1'b1);
    for (int k = 0; k < 12; k++) begin
      if (done) done_bad = 1'b1;
      @(negedge clk);
    end
    check_output("midmul_no_done", done_bad, 1'b0);
    apply_stimulus(OP_LOAD, 8'h05, lat);
    check_output("post_rst_load", acc, 8'h05);

    // Back-to-back ADD 01 with valid held: one accept every three cycles
    apply_stimulus(OP_LOAD, 8'h00, lat);
    bus.i_valid   = 1'b1;
    bus.i_op      = OP_ADD;
    bus.i_operand = 8'h01;
    ready_cnt = 0;
    done_cnt  = 0;
    for (int n = 0; n < 9; n++) begin
      if (bus.o_ready) begin
        ready_cnt++;
        check_output($sformatf("held_accept_slot%0d", n), n % 3, 0);
      end
      if (done) begin
        done_cnt++;
        check_output($sformatf("held_acc%0d", done_cnt), acc, done_cnt);
      end
      @(negedge clk);
    end
    bus.i_valid = 1'b0;
    check_output("held_accepts", ready_cnt, 3);
    check_output("held_dones", done_cnt, 3);
    ref_acc = 8'h03;
    ref_ovf = 1'b0;
    @(negedge clk);
    check_output("held_final_acc", acc, 8'h03);

    // Random operations against the arithmetic model
    for (int r = 0; r < 40; r++) begin
      apply_stimulus(2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)), lat);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
